// File: rtl/nts_rx_pkg.sv
// Shared constants for the NTS RX header parser: protocol values, wordsize
// encodings, reject-reason codes, fixed header offsets and FSM states.
package nts_rx_pkg;

  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
  localparam logic [3:0]  IP_VERSION_4   = 4'd4;
  localparam logic [3:0]  IHL_MIN        = 4'd5;
  localparam logic [7:0]  IP_PROTO_UDP   = 8'd17;

  localparam int OFF_ETHERTYPE = 12;
  localparam int OFF_VER_IHL   = 14;
  localparam int OFF_PROTO     = 23;
  localparam int OFF_IP_HDR    = 14;
  localparam int OFF_UDP_LEN   = 4;
  localparam int OFF_NTP_HDR   = 8;
  localparam int FIELD_LAST    = 5;

  typedef enum logic [2:0] {
    WS_8  = 3'd0,
    WS_16 = 3'd1,
    WS_32 = 3'd2,
    WS_64 = 3'd3
  } wordsize_t;

  typedef enum logic [3:0] {
    REASON_NONE      = 4'd0,
    REASON_ETHERTYPE = 4'd1,
    REASON_VERSION   = 4'd2,
    REASON_IHL       = 4'd3,
    REASON_PROTO     = 4'd4,
    REASON_PORT      = 4'd5,
    REASON_UDP_LEN   = 4'd6,
    REASON_TRUNCATED = 4'd7,
    REASON_TIMEOUT   = 4'd8
  } reason_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4,
    ST_DRAIN = 3'd5
  } state_t;

  function automatic logic [3:0] ws_bytes(input wordsize_t ws);
    return 4'd1 << ws;
  endfunction

endpackage

// File: rtl/nts_rx_header_parser.sv
// Walks the Ethernet/IPv4/UDP headers of a buffered frame with one sized read
// at a time, extracts the fields the NTS engine needs and classifies the frame.
module nts_rx_header_parser
  import nts_rx_pkg::*;
#(
  parameter int ADDR_WIDTH  = 10,
  parameter int NTP_PORT    = 123,
  parameter int MIN_UDP_LEN = 56,
  parameter int TIMEOUT     = 64
) (
  input  logic                  i_clk,
  input  logic                  i_areset,
  input  logic                  i_start,
  input  logic                  i_clear,
  input  logic [ADDR_WIDTH+2:0] i_packet_bytes,
  output logic [ADDR_WIDTH+2:0] o_access_port_addr,
  output logic [2:0]            o_access_port_wordsize,
  output logic                  o_access_port_rd_en,
  input  logic                  i_access_port_wait,
  input  logic                  i_access_port_rd_dv,
  input  logic [63:0]           i_access_port_rd_data,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_accept,
  output logic [3:0]            o_reject_reason,
  output logic [5:0]            o_ip_hdr_bytes,
  output logic [15:0]           o_udp_src_port,
  output logic [15:0]           o_udp_len,
  output logic [63:0]           o_ntp_hdr0
);

  localparam int BA_W  = ADDR_WIDTH + 3;
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_t          state, state_next;
  logic [2:0]      idx;
  logic [BA_W-1:0] packet_bytes;
  logic [CNT_W-1:0] tmo_cnt;
  logic [63:0]     rd_data_q;
  logic [BA_W-1:0] udp_base;
  logic [BA_W-1:0] field_addr;
  wordsize_t       field_ws;
  logic            truncated;
  logic            timed_out;
  logic            last_field;
  reason_t         check_reason;
  logic            start_ok;

  assign udp_base   = BA_W'(OFF_IP_HDR) + BA_W'(o_ip_hdr_bytes);
  assign timed_out  = (tmo_cnt == CNT_W'(TIMEOUT - 1));
  assign last_field = (idx == 3'(FIELD_LAST));
  assign start_ok   = (state == ST_IDLE) && i_start && !i_clear;

  always_comb begin
    field_addr = BA_W'(OFF_ETHERTYPE);
    field_ws   = WS_16;
    case (idx)
      3'd0: begin field_addr = BA_W'(OFF_ETHERTYPE); field_ws = WS_16; end
      3'd1: begin field_addr = BA_W'(OFF_VER_IHL);   field_ws = WS_8;  end
      3'd2: begin field_addr = BA_W'(OFF_PROTO);     field_ws = WS_8;  end
      3'd3: begin field_addr = udp_base;             field_ws = WS_32; end
      3'd4: begin field_addr = udp_base + BA_W'(OFF_UDP_LEN); field_ws = WS_16; end
      default: begin field_addr = udp_base + BA_W'(OFF_NTP_HDR); field_ws = WS_64; end
    endcase
  end

  // One bit wider than the address so the end-of-field sum cannot wrap.
  assign truncated = ({1'b0, field_addr} + (BA_W+1)'(ws_bytes(field_ws)))
                     > {1'b0, packet_bytes};

  always_comb begin
    check_reason = REASON_NONE;
    case (idx)
      3'd0: if (rd_data_q[15:0] != ETHERTYPE_IPV4) check_reason = REASON_ETHERTYPE;
      3'd1: begin
        if (rd_data_q[7:4] != IP_VERSION_4)  check_reason = REASON_VERSION;
        else if (rd_data_q[3:0] < IHL_MIN)   check_reason = REASON_IHL;
      end
      3'd2: if (rd_data_q[7:0] != IP_PROTO_UDP) check_reason = REASON_PROTO;
      3'd3: if (rd_data_q[15:0] != 16'(NTP_PORT)) check_reason = REASON_PORT;
      3'd4: if (rd_data_q[15:0] < 16'(MIN_UDP_LEN)) check_reason = REASON_UDP_LEN;
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_areset) state <= ST_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (start_ok) state_next = ST_ISSUE;
      ST_ISSUE: begin
        if (i_clear)                  state_next = ST_IDLE;
        else if (truncated)           state_next = ST_DONE;
        else if (!i_access_port_wait) state_next = ST_WAIT;
      end
      // A clear that coincides with dv or timeout has nothing left to drain.
      ST_WAIT: begin
        if (i_access_port_rd_dv)  state_next = i_clear ? ST_IDLE : ST_CHECK;
        else if (timed_out)       state_next = i_clear ? ST_IDLE : ST_DONE;
        else if (i_clear)         state_next = ST_DRAIN;
      end
      ST_CHECK: begin
        if (i_clear)                                         state_next = ST_IDLE;
        else if ((check_reason != REASON_NONE) || last_field) state_next = ST_DONE;
        else                                                 state_next = ST_ISSUE;
      end
      ST_DONE:  state_next = ST_IDLE;
      ST_DRAIN: if (i_access_port_rd_dv || timed_out) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    o_access_port_addr     = '0;
    o_access_port_wordsize = 3'(WS_8);
    o_access_port_rd_en    = 1'b0;
    o_busy                 = 1'b0;
    o_done                 = 1'b0;
    case (state)
      ST_ISSUE: begin
        o_access_port_addr     = field_addr;
        o_access_port_wordsize = field_ws;
        o_access_port_rd_en    = !i_clear && !truncated && !i_access_port_wait;
        o_busy                 = 1'b1;
      end
      ST_WAIT, ST_DRAIN: begin
        o_access_port_addr     = field_addr;
        o_access_port_wordsize = field_ws;
        o_busy                 = 1'b1;
      end
      ST_CHECK: o_busy = 1'b1;
      ST_DONE:  o_done = !i_clear;
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_areset) begin
      idx             <= '0;
      packet_bytes    <= '0;
      tmo_cnt         <= '0;
      rd_data_q       <= '0;
      o_accept        <= 1'b0;
      o_reject_reason <= REASON_NONE;
      o_ip_hdr_bytes  <= '0;
      o_udp_src_port  <= '0;
      o_udp_len       <= '0;
      o_ntp_hdr0      <= '0;
    end else begin
      if (start_ok) begin
        idx             <= '0;
        packet_bytes    <= i_packet_bytes;
        o_accept        <= 1'b0;
        o_reject_reason <= REASON_NONE;
        o_ip_hdr_bytes  <= '0;
        o_udp_src_port  <= '0;
        o_udp_len       <= '0;
        o_ntp_hdr0      <= '0;
      end

      if (o_access_port_rd_en)
        tmo_cnt <= '0;
      else if ((state == ST_WAIT) || (state == ST_DRAIN))
        tmo_cnt <= tmo_cnt + CNT_W'(1);

      if ((state == ST_WAIT) && i_access_port_rd_dv)
        rd_data_q <= i_access_port_rd_data;

      if ((state == ST_ISSUE) && !i_clear && truncated)
        o_reject_reason <= REASON_TRUNCATED;

      if ((state == ST_WAIT) && !i_clear && !i_access_port_rd_dv && timed_out)
        o_reject_reason <= REASON_TIMEOUT;

      // Fields are captured as soon as their read lands, even if the check fails.
      if ((state == ST_CHECK) && !i_clear) begin
        case (idx)
          3'd1: o_ip_hdr_bytes <= {rd_data_q[3:0], 2'b00};
          3'd3: o_udp_src_port <= rd_data_q[31:16];
          3'd4: o_udp_len      <= rd_data_q[15:0];
          3'd5: o_ntp_hdr0     <= rd_data_q;
          default: ;
        endcase
        if (check_reason != REASON_NONE) o_reject_reason <= check_reason;
        else if (last_field)             o_accept <= 1'b1;
        else                             idx <= idx + 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_nts_rx_header_parser.sv
// Directed and randomized frames against a byte-array buffer model; expected
// results come from walking the header rules over the same bytes.
module tb_nts_rx_header_parser;

  localparam int ADDR_WIDTH  = 10;
  localparam int NTP_PORT    = 123;
  localparam int MIN_UDP_LEN = 56;
  localparam int TIMEOUT     = 64;

  logic        clk = 1'b0;
  logic        i_areset = 1'b1;
  logic        i_start = 1'b0;
  logic        i_clear = 1'b0;
  logic [12:0] i_packet_bytes = '0;
  logic [12:0] o_access_port_addr;
  logic [2:0]  o_access_port_wordsize;
  logic        o_access_port_rd_en;
  logic        i_access_port_wait = 1'b0;
  logic        i_access_port_rd_dv = 1'b0;
  logic [63:0] i_access_port_rd_data = '0;
  logic        o_busy, o_done, o_accept;
  logic [3:0]  o_reject_reason;
  logic [5:0]  o_ip_hdr_bytes;
  logic [15:0] o_udp_src_port, o_udp_len;
  logic [63:0] o_ntp_hdr0;

  nts_rx_header_parser #(
    .ADDR_WIDTH(ADDR_WIDTH), .NTP_PORT(NTP_PORT),
    .MIN_UDP_LEN(MIN_UDP_LEN), .TIMEOUT(TIMEOUT)
  ) dut (
    .i_clk(clk), .i_areset(i_areset), .i_start(i_start), .i_clear(i_clear),
    .i_packet_bytes(i_packet_bytes),
    .o_access_port_addr(o_access_port_addr),
    .o_access_port_wordsize(o_access_port_wordsize),
    .o_access_port_rd_en(o_access_port_rd_en),
    .i_access_port_wait(i_access_port_wait),
    .i_access_port_rd_dv(i_access_port_rd_dv),
    .i_access_port_rd_data(i_access_port_rd_data),
    .o_busy(o_busy), .o_done(o_done), .o_accept(o_accept),
    .o_reject_reason(o_reject_reason), .o_ip_hdr_bytes(o_ip_hdr_bytes),
    .o_udp_src_port(o_udp_src_port), .o_udp_len(o_udp_len),
    .o_ntp_hdr0(o_ntp_hdr0)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] mem [0:255];
  int rd_addr_q[$], rd_ws_q[$], exp_addr_q[$], exp_ws_q[$];
  int done_cnt = 0;
  int last_rd_cyc = 0;
  bit withhold = 0;
  bit manual_dv = 0;

  int          exp_reason, exp_ihb, exp_src, exp_len;
  bit          exp_accept;
  logic [63:0] exp_ntp;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
    tests++;
    assert (obs === want) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  function automatic logic [63:0] buf_read(input int a, input int n);
    logic [63:0] d = '0;
    for (int i = 0; i < n; i++) d = {d[55:0], mem[(a + i) & 255]};
    return d;
  endfunction

  // Buffer responder: dv follows rd_en after 0..3 idle cycles unless withheld.
  initial begin
    bit          pend = 0;
    int          pdelay = 0;
    logic [63:0] pdata = '0;
    forever begin
      @(negedge clk);
      i_access_port_rd_dv = 1'b0;
      if (manual_dv) begin
        i_access_port_rd_dv = 1'b1;
        i_access_port_rd_data = '0;
        manual_dv = 0;
      end else if (pend) begin
        if (pdelay == 0) begin
          i_access_port_rd_dv = 1'b1;
          i_access_port_rd_data = pdata;
          pend = 0;
        end else pdelay--;
      end
      #1;
      if (o_done) done_cnt++;
      if (o_access_port_rd_en) begin
        rd_addr_q.push_back(int'(o_access_port_addr));
        rd_ws_q.push_back(int'(o_access_port_wordsize));
        last_rd_cyc = cyc;
        if (!withhold) begin
          pend = 1;
          pdelay = $urandom_range(0, 3);
          pdata = buf_read(int'(o_access_port_addr), 1 << o_access_port_wordsize);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic bit step(input int a, input int ws, input int pb);
    if (a + (1 << ws) > pb) begin
      exp_reason = 7;
      return 0;
    end
    exp_addr_q.push_back(a);
    exp_ws_q.push_back(ws);
    return 1;
  endfunction

  // Reference: apply the header rules in order to the bytes in mem.
  task automatic model(input int pb);
    int u, ihl;
    exp_addr_q.delete(); exp_ws_q.delete();
    exp_reason = 0; exp_accept = 0; exp_ihb = 0; exp_src = 0; exp_len = 0; exp_ntp = '0;
    if (!step(12, 1, pb)) return;
    if ({mem[12], mem[13]} != 16'h0800) begin exp_reason = 1; return; end
    if (!step(14, 0, pb)) return;
    ihl = mem[14] & 15;
    exp_ihb = ihl * 4;
    if ((mem[14] >> 4) != 4) begin exp_reason = 2; return; end
    if (ihl < 5) begin exp_reason = 3; return; end
    u = 14 + ihl * 4;
    if (!step(23, 0, pb)) return;
    if (mem[23] != 17) begin exp_reason = 4; return; end
    if (!step(u, 2, pb)) return;
    exp_src = {mem[u], mem[u+1]};
    if ({mem[u+2], mem[u+3]} != NTP_PORT) begin exp_reason = 5; return; end
    if (!step(u + 4, 1, pb)) return;
    exp_len = {mem[u+4], mem[u+5]};
    if (exp_len < MIN_UDP_LEN) begin exp_reason = 6; return; end
    if (!step(u + 8, 3, pb)) return;
    exp_ntp = buf_read(u + 8, 8);
    exp_accept = 1;
  endtask

  task automatic build(input logic [15:0] et, input int ver, input int ihl,
                       input int proto, input logic [15:0] dst, input logic [15:0] len);
    int u;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    u = 14 + ihl * 4;
    {mem[12], mem[13]} = et;
    mem[14] = 8'((ver << 4) | ihl);
    mem[23] = 8'(proto);
    {mem[u+2], mem[u+3]} = dst;
    {mem[u+4], mem[u+5]} = len;
  endtask

  task automatic wait_done(output bit got);
    got = 0;
    for (int c = 0; c < 3000 && !got; c++) begin
      @(negedge clk); #2;
      if (o_done) got = 1;
    end
  endtask

  task automatic run_frame(input string tag, input int pb);
    bit got;
    int n;
    model(pb);
    rd_addr_q.delete(); rd_ws_q.delete();
    @(negedge clk);
    i_packet_bytes = 13'(pb);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    wait_done(got);
    chk({tag, " done"}, got, 1);
    chk({tag, " busy_at_done"}, o_busy, 0);
    chk({tag, " reason"}, o_reject_reason, exp_reason);
    chk({tag, " accept"}, o_accept, exp_accept);
    chk({tag, " ip_hdr_bytes"}, o_ip_hdr_bytes, exp_ihb);
    chk({tag, " src"}, o_udp_src_port, exp_src);
    chk({tag, " len"}, o_udp_len, exp_len);
    chk({tag, " ntp0"}, o_ntp_hdr0, exp_ntp);
    chk({tag, " rd_count"}, rd_addr_q.size(), exp_addr_q.size());
    n = (rd_addr_q.size() < exp_addr_q.size()) ? rd_addr_q.size() : exp_addr_q.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s addr%0d", tag, i), rd_addr_q[i], exp_addr_q[i]);
      chk($sformatf("%s ws%0d", tag, i), rd_ws_q[i], exp_ws_q[i]);
    end
    @(negedge clk); #2;
    chk({tag, " done_one_cycle"}, o_done, 0);
  endtask

  initial begin
    bit got;
    int d0, rc;
    repeat (3) @(negedge clk);
    #2;
    chk("rst busy", o_busy, 0);
    chk("rst done", o_done, 0);
    chk("rst rd_en", o_access_port_rd_en, 0);
    chk("rst addr", o_access_port_addr, 0);
    chk("rst reason", o_reject_reason, 0);
    chk("rst ntp0", o_ntp_hdr0, 0);
    @(negedge clk);
    i_areset = 1'b0;

    build(16'h0800, 4, 5, 17, 16'd123, 16'd56);
    run_frame("ihl5", 120);
    chk("ihl5 addr5_is_42", (exp_addr_q.size() == 6) ? exp_addr_q[5] : -1, 42);
    build(16'h0800, 4, 6, 17, 16'd123, 16'd300);
    run_frame("ihl6", 120);
    build(16'h86DD, 4, 5, 17, 16'd123, 16'd56);
    run_frame("ethertype", 120);
    build(16'h0800, 4, 5, 6, 16'd123, 16'd56);
    run_frame("proto", 120);
    build(16'h0800, 6, 5, 17, 16'd123, 16'd56);
    run_frame("version", 120);
    build(16'h0800, 4, 4, 17, 16'd123, 16'd56);
    run_frame("ihl_small", 120);
    build(16'h0800, 4, 5, 17, 16'd124, 16'd56);
    run_frame("port", 120);
    build(16'h0800, 4, 5, 17, 16'd123, 16'd55);
    run_frame("udp_len", 120);
    build(16'h0800, 4, 5, 17, 16'd123, 16'd56);
    run_frame("trunc40", 40);
    run_frame("exact50", 50);
    run_frame("trunc0", 0);

    // Read that never completes aborts with a timeout.
    build(16'h0800, 4, 5, 17, 16'd123, 16'd56);
    withhold = 1;
    rd_addr_q.delete();
    @(negedge clk);
    i_packet_bytes = 13'd120; i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    wait_done(got);
    chk("tmo done", got, 1);
    chk("tmo reason", o_reject_reason, 8);
    chk("tmo accept", o_accept, 0);
    chk("tmo rd_count", rd_addr_q.size(), 1);
    chk("tmo latency_in_range",
        ((cyc - last_rd_cyc) >= TIMEOUT) && ((cyc - last_rd_cyc) <= TIMEOUT + 2), 1);

    // Clear while waiting: stay busy until dv arrives, never pulse done.
    d0 = done_cnt;
    rd_addr_q.delete();
    @(negedge clk);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    for (int c = 0; c < 50 && rd_addr_q.size() == 0; c++) @(negedge clk);
    chk("clr rd_issued", rd_addr_q.size(), 1);
    @(negedge clk);
    i_clear = 1'b1;
    @(negedge clk);
    i_clear = 1'b0;
    repeat (5) @(negedge clk);
    #2;
    chk("clr busy_draining", o_busy, 1);
    manual_dv = 1;
    repeat (4) @(negedge clk);
    #2;
    chk("clr idle_after_dv", o_busy, 0);
    chk("clr no_done", done_cnt - d0, 0);
    withhold = 0;

    // Buffer busy: no read until wait drops; a second start is ignored.
    build(16'h0800, 4, 7, 17, 16'd123, 16'd90);
    model(120);
    rd_addr_q.delete();
    i_access_port_wait = 1'b1;
    @(negedge clk);
    i_packet_bytes = 13'd120; i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    repeat (4) @(negedge clk);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    repeat (5) @(negedge clk);
    #2;
    chk("wait no_rd_en", rd_addr_q.size(), 0);
    chk("wait busy", o_busy, 1);
    @(negedge clk);
    i_access_port_wait = 1'b0;
    wait_done(got);
    chk("wait done", got, 1);
    chk("wait accept", o_accept, exp_accept);
    chk("wait ntp0", o_ntp_hdr0, exp_ntp);
    rc = rd_addr_q.size();
    chk("wait rd_count", rc, exp_addr_q.size());
    repeat (5) @(negedge clk);
    #2;
    chk("wait start_ignored", o_busy, 0);
    chk("wait no_extra_rd", rd_addr_q.size(), rc);

    for (int t = 0; t < 24; t++) begin
      build(($urandom % 5 == 0) ? 16'h86DD : 16'h0800,
            ($urandom % 6 == 0) ? 6 : 4,
            ($urandom % 6 == 0) ? $urandom_range(0, 4) : $urandom_range(5, 15),
            ($urandom % 6 == 0) ? 6 : 17,
            ($urandom % 5 == 0) ? 16'd124 : 16'd123,
            ($urandom % 5 == 0) ? 16'($urandom_range(0, 55)) : 16'($urandom_range(56, 1500)));
      run_frame($sformatf("rnd%0d", t), ($urandom % 4 == 0) ? $urandom_range(0, 90) : 120);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
